// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: sequences pc/ce toward instruction memory, fills the
// single IF/ID slot, and handles stalls, branch redirects and flushes (incl. in-flight fetches).
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_address,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        imem_rdy,
    output logic [31:0] pc,
    output logic        ce,
    output logic        inst_valid,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] save_q, save_d;
    logic        vld_q, vld_d;

    logic        redirect;
    logic [31:0] tgt;
    logic        accept;
    logic        consume;

    // Flush outranks a branch; a stalled ID stage cannot issue a branch.
    assign redirect = flush | (branch_flag & ~stall);
    assign tgt      = (flush ? new_pc : branch_target_address) & ~32'd3;
    assign accept   = (state_q == FETCH) & imem_rdy & (~vld_q | ~stall);
    assign consume  = vld_q & ~stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        save_d  = save_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) pc_d = tgt;
            end
            FETCH: begin
                if (redirect) begin
                    vld_d = 1'b0;
                    if (imem_rdy) begin
                        pc_d = tgt;
                    end else begin
                        // Request already on the bus; let it complete, then drop it.
                        save_d  = tgt;
                        state_d = DRAIN;
                    end
                end else if (accept) begin
                    vld_d = 1'b1;
                    ipc_d = pc_q;
                    pc_d  = pc_q + 32'd4;
                end else if (consume) begin
                    vld_d = 1'b0;
                end
            end
            DRAIN: begin
                vld_d = 1'b0;
                if (redirect) save_d = tgt;
                if (imem_rdy) begin
                    pc_d    = redirect ? tgt : save_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= 32'd0;
            save_q  <= 32'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            save_q  <= save_d;
            vld_q   <= vld_d;
        end
    end

    assign pc         = pc_q;
    assign ce         = (state_q != IDLE);
    assign inst_valid = vld_q;
    assign inst_pc    = ipc_q;

endmodule
